// File: rtl/apb_slave_regfile.sv
// APB completer register file with byte strobes, wait states
// and a read-only write counter in the last register.
module apb_slave_regfile #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 1,
  parameter logic [PADDR_SIZE-1:0] BASE_ADDR = 16'h0000
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic PSEL,
  input  logic PENABLE,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0] PWDATA,
  input  logic PWRITE,
  output logic [PDATA_SIZE-1:0] PRDATA,
  output logic PREADY,
  output logic PSLVERR,
  output logic [NUM_REGS*PDATA_SIZE-1:0] regs_o
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NB = PDATA_SIZE / 8;
  localparam logic [PADDR_SIZE-1:0] NR = PADDR_SIZE'(NUM_REGS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state;
  logic [3:0] cnt;
  logic [IW-1:0] idx;
  logic wr;
  logic err;
  logic ready;
  logic [PDATA_SIZE-1:0] regs [NUM_REGS];

  logic [PADDR_SIZE-1:0] off;
  logic [PADDR_SIZE-1:0] word;
  logic bad;
  logic setup;
  logic done;

  // Address decode and handshake qualifiers
  always_comb begin
    off = PADDR - BASE_ADDR;
    word = {2'b00, off[PADDR_SIZE-1:2]};
    bad = (off[1:0] != 2'b00)
        | (PADDR < BASE_ADDR)
        | (word >= NR)
        | (PWRITE & (word == NR - 1'b1));
    setup = (state == IDLE) & PSEL & ~PENABLE;
    done = (state == ACCESS) & PSEL & PENABLE & ready;
  end

  // Transfer FSM; PREADY is a flop so inputs never reach it combinationally
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      wr <= 1'b0;
      err <= 1'b0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            idx <= bad ? '0 : word[IW-1:0];
            wr <= PWRITE;
            err <= bad;
            cnt <= '0;
            ready <= (WS == 4'd0);
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
            ready <= 1'b0;
          end else if (ready) begin
            if (PENABLE) begin
              state <= IDLE;
              ready <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
            ready <= (cnt + 4'd1 == WS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register writes with byte lanes and the completed-write counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (done && wr && !err) begin
      for (int b = 0; b < NB; b++) begin
        if (PSTRB[b]) regs[idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
      end
      regs[NUM_REGS-1] <= regs[NUM_REGS-1] + 1'b1;
    end
  end

  // Response outputs gated by completion
  always_comb begin
    PREADY = ready;
    PSLVERR = ready & err;
    PRDATA = (ready & ~wr & ~err) ? regs[idx] : '0;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_o[g*PDATA_SIZE +: PDATA_SIZE] = regs[g];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: one instance with
// one wait state, one with none, sharing the APB bus.
module tb_apb_slave_regfile;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] psel;
  logic penable;
  logic [15:0] paddr;
  logic [3:0] pstrb;
  logic [31:0] pwdata;
  logic pwrite;
  logic [31:0] prdata0, prdata1;
  logic pready0, pready1;
  logic pslverr0, pslverr1;
  logic [255:0] regs0, regs1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic err;
    int cyc;
  } exp_t;

  exp_t q[$];
  logic [31:0] m [2][8];

  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_STATES(1)) u0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]),
    .PENABLE(penable), .PADDR(paddr), .PSTRB(pstrb),
    .PWDATA(pwdata), .PWRITE(pwrite), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .regs_o(regs0)
  );

  apb_slave_regfile #(.WAIT_STATES(0)) u1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]),
    .PENABLE(penable), .PADDR(paddr), .PSTRB(pstrb),
    .PWDATA(pwdata), .PWRITE(pwrite), .PRDATA(prdata1),
    .PREADY(pready1), .PSLVERR(pslverr1), .regs_o(regs1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  function automatic logic [31:0] prd(input int d);
    return (d == 0) ? prdata0 : prdata1;
  endfunction

  function automatic logic perr(input int d);
    return (d == 0) ? pslverr0 : pslverr1;
  endfunction

  function automatic logic [31:0] rget(input int d, input int i);
    return (d == 0) ? regs0[i*32 +: 32] : regs1[i*32 +: 32];
  endfunction

  task automatic chk_regs(input int d, input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_reg%0d", tag, i), rget(d, i), m[d][i]);
  endtask

  // Called at a negedge; returns at the negedge after completion
  task automatic xfer(input int d, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic w, input string tag);
    exp_t e;
    exp_t r;
    int cyc;
    int ix;
    logic bad;
    ix = int'(a >> 2);
    bad = (a[1:0] != 2'b00) || (ix >= 8) || (w && ix == 7);
    e.err = bad;
    e.rd = (!w && !bad) ? m[d][ix] : 32'h0;
    e.cyc = (d == 0) ? 3 : 2;
    q.push_back(e);
    if (w && !bad) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) m[d][ix][b*8 +: 8] = wd[b*8 +: 8];
      m[d][7] = m[d][7] + 32'd1;
    end
    psel = 2'b00;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr = a;
    pwdata = wd;
    pstrb = st;
    pwrite = w;
    @(negedge clk);
    penable = 1'b1;
    cyc = 2;
    while (!rdy(d) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    r = q.pop_front();
    chk({tag, "_rdata"}, prd(d), r.rd);
    chk({tag, "_slverr"}, 32'(perr(d)), 32'(r.err));
    chk({tag, "_cycles"}, cyc, r.cyc);
    @(negedge clk);
    psel = 2'b00;
    penable = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) m[d][i] = 32'h0;
    rst_n = 1'b0;
    psel = 2'b00;
    penable = 1'b0;
    paddr = '0;
    pstrb = '0;
    pwdata = '0;
    pwrite = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(pready0), 32'h0);
    chk("rst_pslverr", 32'(pslverr0), 32'h0);
    chk("rst_prdata", prdata0, 32'h0);
    chk_regs(0, "rst");
    rst_n = 1'b1;
    @(negedge clk);

    xfer(0, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b1, "wr1");
    chk("wr1_reg1", rget(0, 1), 32'hDEADBEEF);
    chk("wr1_cnt", rget(0, 7), 32'd1);
    xfer(0, 16'h0004, 32'h0, 4'h0, 1'b0, "rd1");
    xfer(0, 16'h0004, 32'h11223344, 4'b0101, 1'b1, "part");
    chk("part_reg1", rget(0, 1), 32'hDE22BE44);
    chk("part_cnt", rget(0, 7), 32'd2);

    xfer(0, 16'h001C, 32'h12345678, 4'hF, 1'b1, "ro");
    xfer(0, 16'h0020, 32'h0, 4'h0, 1'b0, "oor");
    xfer(0, 16'h0002, 32'hA5A5A5A5, 4'hF, 1'b1, "mis");
    chk_regs(0, "err");
    xfer(0, 16'h001C, 32'h0, 4'h0, 1'b0, "rdcnt");

    xfer(0, 16'h0000, 32'h01010101, 4'hF, 1'b1, "b2b0");
    xfer(0, 16'h0008, 32'h02020202, 4'hF, 1'b1, "b2b1");
    xfer(0, 16'h000C, 32'h03030303, 4'h0, 1'b1, "b2b2");
    chk("b2b_cnt", rget(0, 7), 32'd5);
    chk_regs(0, "b2b");

    psel[0] = 1'b1;
    penable = 1'b1;
    @(negedge clk);
    chk("viol_pready", 32'(pready0), 32'h0);
    @(negedge clk);
    chk("viol_pready2", 32'(pready0), 32'h0);
    psel = 2'b00;
    penable = 1'b0;
    @(negedge clk);

    psel[0] = 1'b1;
    penable = 1'b0;
    paddr = 16'h0000;
    pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF;
    pstrb = 4'hF;
    @(negedge clk);
    psel[0] = 1'b0;
    @(negedge clk);
    chk("abort_pready", 32'(pready0), 32'h0);
    @(negedge clk);
    chk_regs(0, "abort");
    xfer(0, 16'h0000, 32'h0, 4'h0, 1'b0, "post_abort");

    xfer(1, 16'h0000, 32'h0, 4'h0, 1'b0, "z_rd0");
    xfer(1, 16'h0008, 32'hCAFEF00D, 4'hF, 1'b1, "z_wr");
    xfer(1, 16'h0008, 32'h0, 4'h0, 1'b0, "z_rd");
    chk_regs(1, "z");

    psel[0] = 1'b1;
    penable = 1'b0;
    paddr = 16'h0004;
    pwrite = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("pre_rst_rdata", prdata0, m[0][1]);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) m[d][i] = 32'h0;
    chk("mid_rst_pready", 32'(pready0), 32'h0);
    chk("mid_rst_pslverr", 32'(pslverr0), 32'h0);
    chk("mid_rst_prdata", prdata0, 32'h0);
    chk_regs(0, "mid_rst");
    chk_regs(1, "mid_rst_z");
    psel = 2'b00;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(0, 16'h0000, 32'h0, 4'h0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
